// File: rtl/data_bus_responder_pkg.sv
// Shared bus definitions for the data bus responder: FSM state encoding,
// bus widths and the wait-counter width.
package data_bus_responder_pkg;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 32;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   // Word-address width for a RAM of the given depth (never below 1 bit).
   function automatic int word_addr_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/data_bus_responder_ram.sv
// Single-port word RAM with synchronous read and write enable.
// Contents are never reset.
module data_memory_ram
   import data_bus_responder_pkg::*;
#(
   parameter int WORDS = 1024,
   parameter int AW    = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [WORDS];
   logic [DATA_W-1:0] r_rdata;

   // Read every cycle from the presented address; write when enabled.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_bus_responder.sv
// Memory-mapped RAM responder: accepts one level-held read/write request at a
// time, optionally inserts wait states, and completes with a one-cycle
// response pulse. Out-of-range accesses complete with access_error.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; a request here is latched and accepted
// WAIT    | counting down WAIT_STATES extra cycles for the latched request
// RESPOND | response pulse; a latched in-range write commits at its end
//
// BASE_ADDRESS is assumed word aligned, so address[1:0] never changes the
// range decision or the word index.
module data_bus_responder
   import data_bus_responder_pkg::*;
#(
   parameter int          MEMORY_WORDS = 1024,
   parameter int          WAIT_STATES  = 0,
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memory_read,
   input  logic              memory_write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              response,
   output logic              access_error
);

   localparam int                    AW        = word_addr_w(MEMORY_WORDS);
   localparam logic [ADDR_W:0]       SPAN      = (ADDR_W+1)'(MEMORY_WORDS) << 2;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = (WAIT_STATES > 0) ?
                                                 WAIT_CNT_W'(WAIT_STATES - 1) :
                                                 '0;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_accept;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;

   logic [AW-1:0]         r_addr_idx;
   logic                  r_in_range;
   logic                  r_is_write;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_read_data;

   logic [ADDR_W-1:0]     w_offset;
   logic                  w_in_range;
   logic [AW-1:0]         w_word_idx;
   logic [AW-1:0]         w_ram_addr;
   logic                  w_ram_we;
   logic [DATA_W-1:0]     w_ram_q;
   logic [DATA_W-1:0]     w_read_value;
   logic                  w_responding;

   assign w_offset   = address - BASE_ADDRESS;
   assign w_in_range = (address >= BASE_ADDRESS) && ({1'b0, w_offset} < SPAN);
   assign w_word_idx = AW'(w_offset >> 2);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; requests are only looked at in IDLE.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (memory_read || memory_write) begin
               w_accept     = 1'b1;
               w_next_state = (WAIT_STATES > 0) ? WAIT : RESPOND;
            end
         end
         WAIT: begin
            if (r_wait_cnt == '0) begin
               w_next_state = RESPOND;
            end
         end
         RESPOND: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Wait-state down-counter, loaded on accept, terminal count at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (w_accept) begin
         r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
         r_wait_cnt <= r_wait_cnt - 1'b1;
      end
   end

   // Latch the request on accept; a simultaneous read+write counts as a write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr_idx <= '0;
         r_in_range <= 1'b0;
         r_is_write <= 1'b0;
         r_wdata    <= '0;
      end else if (w_accept) begin
         r_addr_idx <= w_word_idx;
         r_in_range <= w_in_range;
         r_is_write <= memory_write;
         r_wdata    <= write_data;
      end
   end

   assign w_responding = (r_state == RESPOND);
   assign w_read_value = r_in_range ? w_ram_q : '0;

   // Remember the last read result so it is held between read responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_read_data <= '0;
      end else if (w_responding && !r_is_write) begin
         r_read_data <= w_read_value;
      end
   end

   // In IDLE the RAM looks up the incoming address so the word is ready one
   // cycle after accept; afterwards it keeps reading the latched index.
   assign w_ram_addr = (r_state == IDLE) ? w_word_idx : r_addr_idx;
   assign w_ram_we   = w_responding && r_is_write && r_in_range;

   data_memory_ram #(
      .WORDS (MEMORY_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_q)
   );

   assign response     = w_responding;
   assign access_error = w_responding && !r_in_range;
   assign read_data    = (w_responding && !r_is_write) ? w_read_value : r_read_data;

endmodule
